// File: rtl/uart_bus_bridge_pkg.sv
// Command bytes, response bytes and FSM states shared by the UART bus bridge.
package uart_bridge_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} state_t;

    function automatic logic known_op(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ);
    endfunction

endpackage

// File: rtl/uart_bus_bridge.sv
// UART command bridge: decodes 'W'/'R' byte commands into single bus transfers and streams the response back.
// Latency: one cycle per accepted byte, bus phase as long as the bus takes to ack; no idle gap between commands.
// Backpressure: rx tready low outside IDLE/ADDR/WDATA; tx byte held stable until accepted. Optional UART_BRIDGE_TIMEOUT_EN.
module uart_bus_bridge
    import uart_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    output logic [7:0]            output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic                  bus_we,
    output logic                  bus_req,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_ack,
    output logic                  busy,
    output logic                  cmd_error
);

    localparam int ADDR_BYTES = ADDR_WIDTH / 8;
    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam logic [DATA_WIDTH-1:0] ACK_WORD = DATA_WIDTH'(RSP_ACK) << (DATA_WIDTH - 8);
    localparam logic [DATA_WIDTH-1:0] NAK_WORD = DATA_WIDTH'(RSP_NAK) << (DATA_WIDTH - 8);

    state_t                state, state_nxt;
    logic [7:0]            byte_cnt;
    logic [7:0]            resp_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] resp_sr;
    logic                  is_write;
    logic                  in_fire;
    logic                  out_fire;
    logic                  bus_done;
    logic                  tmo_hit;

    assign in_fire           = input_axis_tvalid && input_axis_tready;
    assign out_fire          = output_axis_tvalid && output_axis_tready;
    assign bus_done          = bus_req && bus_ack;
    assign output_axis_tdata = resp_sr[DATA_WIDTH-1 -: 8];
    assign bus_addr          = addr_q;
    assign bus_wdata         = wdata_q;
    assign bus_we            = is_write;

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          collecting;

    // Idle time is measured from state entry or the last accepted byte; a byte arriving on the limit cycle wins.
    assign collecting = (state == ADDR) || (state == WDATA);
    assign tmo_hit    = collecting && !in_fire && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 tmo_cnt <= '0;
        else if (!collecting || in_fire || tmo_hit) tmo_cnt <= '0;
        else                                     tmo_cnt <= tmo_cnt + TW'(1);
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (in_fire) state_nxt = known_op(input_axis_tdata) ? ADDR : RESP;
            ADDR:  if (in_fire && byte_cnt == 8'(ADDR_BYTES - 1)) state_nxt = is_write ? WDATA : BUS;
                   else if (tmo_hit) state_nxt = IDLE;
            WDATA: if (in_fire && byte_cnt == 8'(DATA_BYTES - 1)) state_nxt = BUS;
                   else if (tmo_hit) state_nxt = IDLE;
            BUS:   if (bus_done) state_nxt = RESP;
            RESP:  if (out_fire && resp_cnt == 8'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            busy               <= 1'b0;
            input_axis_tready  <= 1'b0;
            output_axis_tvalid <= 1'b0;
            bus_req            <= 1'b0;
            cmd_error          <= 1'b0;
            is_write           <= 1'b0;
            byte_cnt           <= '0;
            resp_cnt           <= '0;
            addr_q             <= '0;
            wdata_q            <= '0;
            resp_sr            <= '0;
        end else begin
            state              <= state_nxt;
            busy               <= (state_nxt != IDLE);
            input_axis_tready  <= (state_nxt inside {IDLE, ADDR, WDATA});
            output_axis_tvalid <= (state_nxt == RESP);
            // Request rises the cycle after BUS entry and falls the cycle after the ack.
            bus_req            <= (state == BUS) && !bus_done;
            cmd_error          <= tmo_hit || (state == IDLE && in_fire && !known_op(input_axis_tdata));

            case (state)
                IDLE: if (in_fire) begin
                    is_write <= (input_axis_tdata == OP_WRITE);
                    byte_cnt <= '0;
                    if (!known_op(input_axis_tdata)) begin
                        resp_sr  <= NAK_WORD;
                        resp_cnt <= 8'd1;
                    end
                end
                ADDR: if (in_fire) begin
                    addr_q   <= (addr_q << 8) | ADDR_WIDTH'(input_axis_tdata);
                    byte_cnt <= (byte_cnt == 8'(ADDR_BYTES - 1)) ? 8'd0 : byte_cnt + 8'd1;
                end
                WDATA: if (in_fire) begin
                    wdata_q  <= (wdata_q << 8) | DATA_WIDTH'(input_axis_tdata);
                    byte_cnt <= (byte_cnt == 8'(DATA_BYTES - 1)) ? 8'd0 : byte_cnt + 8'd1;
                end
                BUS: if (bus_done) begin
                    resp_sr  <= is_write ? ACK_WORD : bus_rdata;
                    resp_cnt <= is_write ? 8'd1 : 8'(DATA_BYTES);
                end
                RESP: if (out_fire) begin
                    resp_sr  <= resp_sr << 8;
                    resp_cnt <= resp_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
